// File: rtl/instr_fetch.sv
// Instruction fetch front end: credit-limited request stream into instruction
// memory, in-order response buffer toward the decoder, redirect with stale-response discard.
// Latency: grant -> instr_valid is memory latency + 1 cycle.
// Backpressure: dec_ready=0 holds the head; new requests stop once in-flight + buffered reach DEPTH.
//
// Ports:
//   clk, nrst                      clock, synchronous active-high reset
//   redirect, redirect_pc          new fetch target (low two bits ignored)
//   imem_req/addr/gnt              request channel to instruction memory
//   imem_rvalid/rdata              in-order response channel
//   instr_valid/instr/instr_pc     buffer head toward the decoder
//   dec_ready                      decoder consumes the head
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        dec_ready
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   buf_pc    [DEPTH];
    logic [31:0]   buf_instr [DEPTH];

    logic [CW:0]   credit_used;
    logic          grant;
    logic          rsp;
    logic          push;
    logic          pop;
    logic          unused_low_bits;

    assign unused_low_bits = ^redirect_pc[1:0];

    // Every in-flight request owns a buffer slot, so a response can never
    // arrive to a full buffer.
    assign credit_used = {1'b0, outstanding} + {1'b0, count};
    assign imem_req    = !nrst && !redirect && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr   = fetch_pc;

    assign grant = imem_req && imem_gnt;
    // A response with nothing outstanding is spurious and ignored.
    assign rsp   = imem_rvalid && (outstanding != '0);
    // Responses to requests issued before a redirect are counted off by discard.
    assign push  = rsp && !redirect && (discard == '0);
    assign pop   = instr_valid && dec_ready && !redirect;

    assign instr_valid = (count != '0);
    assign instr       = buf_instr[rd_ptr];
    assign instr_pc    = buf_pc[rd_ptr];

    always_ff @(posedge clk) begin
        if (nrst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect) begin
            // Everything still in flight belongs to the abandoned stream,
            // including anything already marked for discard.
            fetch_pc    <= {redirect_pc[31:2], 2'b00};
            resp_pc     <= {redirect_pc[31:2], 2'b00};
            outstanding <= outstanding - CW'(rsp);
            discard     <= outstanding - CW'(rsp);
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            case ({grant, rsp})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
            if (rsp && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
                wr_ptr  <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Buffer storage carries no reset; count gates its visibility.
    always_ff @(posedge clk) begin
        if (push && !nrst) begin
            buf_pc[wr_ptr]    <= resp_pc;
            buf_instr[wr_ptr] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        nrst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        dec_ready;

    instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .dec_ready   (dec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Directed vector table
    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        dr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic redir, input logic [31:0] rpc, input logic gnt,
                       input logic rv, input logic [31:0] rdata, input logic dr,
                       input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_pc, input logic [31:0] e_instr);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.dr = dr;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
        tbl.push_back(v);
    endtask

    // Reference model: in-flight request list and expected buffer contents
    typedef struct {
        logic [31:0] addr;
        bit          live;
        int          gcyc;
    } infl_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    infl_t       inflight[$];
    ent_t        mfifo[$];
    logic [31:0] m_fetch;
    int          cyc;
    logic [31:0] gnt_log[$];
    logic [31:0] pop_log[$];
    int          pop_cyc[$];
    bit          force_redir;
    logic [31:0] force_pc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b1;
        imem_rvalid = 1'b0; imem_rdata = '0; dec_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk1("reset_imem_req", imem_req, 1'b0);
        chk1("reset_instr_valid", instr_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b0;
        inflight.delete(); mfifo.delete(); gnt_log.delete(); pop_log.delete(); pop_cyc.delete();
        m_fetch = RESET_PC; cyc = 0; force_redir = 1'b0;
    endtask

    task automatic model_cycle(input int p_gnt, input int p_rv, input int p_dr, input int p_redir);
        logic  exp_req;
        bit    rsp;
        bit    pop;
        infl_t hd;
        ent_t  e;
        redirect = 1'b0;
        redirect_pc = $urandom();
        if (force_redir) begin
            redirect = 1'b1;
            redirect_pc = force_pc;
            force_redir = 1'b0;
        end else if ($urandom_range(99) < p_redir) begin
            redirect = 1'b1;
            if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFFF;
        end
        imem_gnt = ($urandom_range(99) < p_gnt);
        rsp = (inflight.size() > 0) && (inflight[0].gcyc < cyc) && ($urandom_range(99) < p_rv);
        imem_rvalid = rsp;
        imem_rdata = rsp ? memf(inflight[0].addr) : $urandom();
        // Stray response with nothing outstanding must be ignored.
        if (!rsp && inflight.size() == 0 && $urandom_range(99) < 2) imem_rvalid = 1'b1;
        dec_ready = ($urandom_range(99) < p_dr);
        #1;
        exp_req = !redirect && ((inflight.size() + mfifo.size()) < DEPTH);
        chk1("imem_req", imem_req, exp_req);
        chk32("imem_addr", imem_addr, m_fetch);
        chk1("instr_valid", instr_valid, mfifo.size() != 0);
        if (mfifo.size() != 0) begin
            chk32("instr_pc", instr_pc, mfifo[0].pc);
            chk32("instr", instr, mfifo[0].ins);
        end
        pop = (mfifo.size() != 0) && dec_ready && !redirect;
        if (pop) begin
            e = mfifo.pop_front();
            pop_log.push_back(e.pc);
            pop_cyc.push_back(cyc);
        end
        if (redirect) begin
            mfifo.delete();
            foreach (inflight[i]) inflight[i].live = 1'b0;
            if (rsp) hd = inflight.pop_front();
            m_fetch = {redirect_pc[31:2], 2'b00};
        end else begin
            if (rsp) begin
                hd = inflight.pop_front();
                if (hd.live) mfifo.push_back('{pc: hd.addr, ins: memf(hd.addr)});
            end
            if (exp_req && imem_gnt) begin
                inflight.push_back('{addr: m_fetch, live: 1'b1, gcyc: cyc});
                gnt_log.push_back(m_fetch);
                m_fetch = m_fetch + 32'd4;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; dec_ready = 1'b0;

        // redir rpc gnt rv rdata dr | req addr valid pc instr
        row(1'b1, 32'h10,  1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0);
        row(1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10,  1'b0, 32'h0,   32'h0);
        row(1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h14,  1'b0, 32'h0,   32'h0);
        row(1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h18,  1'b0, 32'h0,   32'h0);
        row(1'b1, 32'h103, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h1C,  1'b0, 32'h0,   32'h0);
        row(1'b0, 32'h0,   1'b0, 1'b1, 32'hDEAD_0010, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   32'h0);
        row(1'b0, 32'h0,   1'b1, 1'b1, 32'hDEAD_0014, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   32'h0);
        row(1'b0, 32'h0,   1'b0, 1'b1, 32'hDEAD_0018, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0,   32'h0);
        row(1'b0, 32'h0,   1'b0, 1'b1, 32'h1111_0100, 1'b0, 1'b1, 32'h104, 1'b0, 32'h0,   32'h0);
        row(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h104, 1'b1, 32'h100, 32'h1111_0100);
        row(1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h104, 1'b1, 32'h100, 32'h1111_0100);
        row(1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h108, 1'b1, 32'h100, 32'h1111_0100);
        row(1'b1, 32'h200, 1'b1, 1'b1, 32'h2222_0104, 1'b1, 1'b0, 32'h10C, 1'b1, 32'h100, 32'h1111_0100);
        row(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   32'h0);
        row(1'b0, 32'h0,   1'b1, 1'b1, 32'h2222_0108, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   32'h0);
        row(1'b0, 32'h0,   1'b0, 1'b1, 32'h3333_0200, 1'b1, 1'b1, 32'h204, 1'b0, 32'h0,   32'h0);
        row(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h204, 1'b1, 32'h200, 32'h3333_0200);
        row(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h204, 1'b0, 32'h0,   32'h0);

        do_reset();
        foreach (tbl[i]) begin
            redirect = tbl[i].redir; redirect_pc = tbl[i].rpc; imem_gnt = tbl[i].gnt;
            imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rdata; dec_ready = tbl[i].dr;
            #1;
            chk1($sformatf("tbl%0d_req", i), imem_req, tbl[i].e_req);
            chk32($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk1($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                chk32($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].e_pc);
                chk32($sformatf("tbl%0d_instr", i), instr, tbl[i].e_instr);
            end
            @(posedge clk);
            @(negedge clk);
        end

        // Streaming: always granted, 1-cycle memory, decoder always ready.
        do_reset();
        repeat (10) model_cycle(100, 100, 100, 0);
        chk1("stream_pop_count", pop_log.size() >= 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i < pop_log.size()) begin
                chk32($sformatf("stream_pc%0d", i), pop_log[i], RESET_PC + 32'(4 * i));
                chk32($sformatf("stream_cyc%0d", i), 32'(pop_cyc[i]), 32'(2 + i));
            end
        end

        // Decoder stalled: buffer fills, requests stop at DEPTH.
        do_reset();
        repeat (20) model_cycle(100, 100, 0, 0);
        chk32("stall_grants", 32'(gnt_log.size()), 32'(DEPTH));
        chk1("stall_req", imem_req, 1'b0);
        chk1("stall_valid", instr_valid, 1'b1);
        chk32("stall_pc", instr_pc, RESET_PC);

        // Redirect to the top word: addresses and PCs wrap to zero.
        gnt_log.delete(); pop_log.delete(); pop_cyc.delete();
        force_redir = 1'b1; force_pc = 32'hFFFF_FFFC;
        repeat (12) model_cycle(100, 100, 100, 0);
        chk1("wrap_counts", (gnt_log.size() >= 2) && (pop_log.size() >= 2), 1'b1);
        if (gnt_log.size() >= 2) begin
            chk32("wrap_gnt0", gnt_log[0], 32'hFFFF_FFFC);
            chk32("wrap_gnt1", gnt_log[1], 32'h0000_0000);
        end
        if (pop_log.size() >= 2) begin
            chk32("wrap_pc0", pop_log[0], 32'hFFFF_FFFC);
            chk32("wrap_pc1", pop_log[1], 32'h0000_0000);
        end

        // Long randomized run with stalls and redirects.
        do_reset();
        repeat (10000) model_cycle(70, 60, 60, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, instruction buffer entries; power of two, 2..16.
REQ-003 clk  input  1  rising-edge clock, sole clock.
REQ-004 nrst  input  1  reset; synchronous, active-high (1 = reset).
REQ-005 redirect  input  1  branch/jump/trap redirect request from execute/commit.
REQ-006 redirect_pc  input  32  new fetch target; bits [1:0] ignored, treated as 00.
REQ-007 imem_req  output  1  instruction memory request valid.
REQ-008 imem_addr  output  32  word-aligned request address.
REQ-009 imem_gnt  input  1  request accepted this cycle when imem_req=1.
REQ-010 imem_rvalid  input  1  response valid; responses return in request order, min 1 cycle after grant.
REQ-011 imem_rdata  input  32  instruction word qualified by imem_rvalid.
REQ-012 instr_valid  output  1  buffer head valid toward instr_decoder.
REQ-013 instr  output  32  head instruction word (op/funct fields sliced by decoder).
REQ-014 instr_pc  output  32  PC of head instruction.
REQ-015 dec_ready  input  1  decoder consumes head when instr_valid=1.

Function
REQ-016 State: fetch_pc, resp_pc (32b each), outstanding and discard counters (0..DEPTH), FIFO of DEPTH {pc,instr} entries with count.
REQ-017 Credit rule: imem_req=1 iff !nrst && !redirect && (outstanding + count) < DEPTH; imem_addr=fetch_pc.
REQ-018 On imem_req && imem_gnt: fetch_pc += 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), outstanding += 1.
REQ-019 On imem_rvalid: outstanding -= 1; if discard>0, response dropped and discard -= 1; else {resp_pc, imem_rdata} pushed, resp_pc += 4.
REQ-020 Grant and rvalid in same cycle: outstanding unchanged.
REQ-021 instr_valid = (count != 0); instr/instr_pc = head entry, held stable while instr_valid && !dec_ready.
REQ-022 Pop on instr_valid && dec_ready; simultaneous push and pop leaves count unchanged, order preserved.
REQ-023 Push never occurs when full (guaranteed by REQ-017); imem_rvalid with outstanding=0 ignored.
REQ-024 Redirect cycle: FIFO cleared (count=0, pop ignored), fetch_pc and resp_pc <= {redirect_pc[31:2],2'b00}, any rvalid that cycle dropped, discard <= outstanding - imem_rvalid.
REQ-025 instr_valid remains 0 after redirect until first post-redirect response pushes; latency grant->instr_valid = memory latency + 1 cycle.
REQ-026 Redirect while discard>0: discard recomputed per REQ-024 (cumulative; no response from old stream ever reaches FIFO).
REQ-027 Back-to-back redirects: last one wins; each cycle of redirect holds imem_req=0.

Reset
REQ-028 nrst=1 at clock edge: fetch_pc=resp_pc=RESET_PC, outstanding=discard=count=0, FIFO pointers 0.
REQ-029 During reset imem_req=0, instr_valid=0; instr/instr_pc don't-care.
REQ-030 Reset mid-operation abandons in-flight requests; memory subsystem is reset together with this block, no stale rvalid expected.
REQ-031 First cycle after reset release: imem_req=1, imem_addr=RESET_PC.

Verification
REQ-032 Reset release, gnt=1 always, 1-cycle latency, dec_ready=1 -> instr_pc sequence 0,4,8,12 one per cycle, instr matches memory.
REQ-033 dec_ready=0 forever, DEPTH=4 -> exactly 4 grants, then imem_req=0; count=4, instr_pc=0 held stable.
REQ-034 3 requests outstanding (addr 0x10,0x14,0x18), redirect_pc=0x103 -> next imem_addr=0x100; three responses dropped; first instr_pc=0x100.
REQ-035 Redirect same cycle as rvalid and dec_ready pop -> that response dropped, FIFO empty next cycle, discard=outstanding-1.
REQ-036 Redirect to 0xFFFF_FFFC -> fetch addrs 0xFFFF_FFFC then 0x0000_0000; instr_pc wraps identically.
REQ-037 Random gnt/rvalid/dec_ready stalls 10k cycles vs reference model -> no drop, duplicate, or reorder; outstanding+count<=DEPTH always.
